// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: requester ids and FSM states.
// No logic; constants only. Optional feature macro: MEM_ARB_RR_EN (used by mem_arbiter).
// Ids double as the 1-bit tag stored per outstanding read.
package mem_arb_pkg;

  // Requester ids (also the tag pushed into the outstanding-read FIFO)
  localparam logic ID_IC = 1'b0;
  localparam logic ID_DC = 1'b1;

  // Arbiter FSM states
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WDATA = 1'b1;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// Purpose: in-order tag FIFO remembering which requester owns each outstanding read.
// Latency: push/pop take effect at the clock edge; head/full/empty are registered views.
// Backpressure: none internally; caller must not push when full or pop when empty.
module mem_arb_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;

  // Next-state: write at wr_ptr, advance pointers, count tracks push minus pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + (PW+1)'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one memory port between icache and dcache; routes in-order read responses back.
// Latency: zero-cycle request pass-through; write owner holds the port until its data beat fires.
// Backpressure: winner sees mem_req_rdy, loser sees 0; reads stall when the tag FIFO is full.
// Optional feature: define MEM_ARB_RR_EN for round-robin; otherwise dc always beats ic.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 28,
  parameter int MEM_DATA_BITS = 128,
  parameter int MAX_OUTST     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ic_req_val,
  output logic                       ic_req_rdy,
  input  logic [MEM_ADDR_BITS-1:0]   ic_req_addr,
  input  logic                       ic_req_rw,
  input  logic                       ic_req_data_valid,
  output logic                       ic_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   ic_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] ic_req_data_mask,
  output logic                       ic_resp_val,
  output logic [MEM_DATA_BITS-1:0]   ic_resp_data,
  input  logic                       dc_req_val,
  output logic                       dc_req_rdy,
  input  logic [MEM_ADDR_BITS-1:0]   dc_req_addr,
  input  logic                       dc_req_rw,
  input  logic                       dc_req_data_valid,
  output logic                       dc_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                       dc_resp_val,
  output logic [MEM_DATA_BITS-1:0]   dc_resp_data,
  output logic                       mem_req_val,
  input  logic                       mem_req_rdy,
  output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  output logic                       mem_req_rw,
  output logic                       mem_req_data_valid,
  input  logic                       mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                       mem_resp_val,
  input  logic [MEM_DATA_BITS-1:0]   mem_resp_data,
  output logic                       arb_err
);

  logic [0:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       err_q, err_d;
`ifdef MEM_ARB_RR_EN
  logic       rr_q, rr_d;
`endif

  logic ic_elig, dc_elig, win_vld, win_id, win_rw, accept;
  logic data_act, data_own, data_fire;
  logic push, pop, fifo_head, fifo_full, fifo_empty;

  // Request arbitration: eligibility (reads need a free tag slot), winner pick, port steering
  always_comb begin
    ic_elig = !reset && (state_q == ST_IDLE) && ic_req_val && (ic_req_rw || !fifo_full);
    dc_elig = !reset && (state_q == ST_IDLE) && dc_req_val && (dc_req_rw || !fifo_full);
    win_vld = ic_elig || dc_elig;
`ifdef MEM_ARB_RR_EN
    win_id  = (ic_elig && dc_elig) ? rr_q : (dc_elig ? ID_DC : ID_IC);
`else
    win_id  = dc_elig ? ID_DC : ID_IC;
`endif
    win_rw       = (win_id == ID_DC) ? dc_req_rw : ic_req_rw;
    mem_req_val  = win_vld;
    mem_req_addr = (win_id == ID_DC) ? dc_req_addr : ic_req_addr;
    mem_req_rw   = win_vld && win_rw;
    ic_req_rdy   = win_vld && (win_id == ID_IC) && mem_req_rdy;
    dc_req_rdy   = win_vld && (win_id == ID_DC) && mem_req_rdy;
    accept       = win_vld && mem_req_rdy;
  end

  // Write-data channel: open during WDATA, or in the very cycle a write is accepted
  always_comb begin
    data_act           = !reset && ((state_q == ST_WDATA) || (accept && win_rw));
    data_own           = (state_q == ST_WDATA) ? owner_q : win_id;
    mem_req_data_valid = data_act &&
                         ((data_own == ID_DC) ? dc_req_data_valid : ic_req_data_valid);
    mem_req_data_bits  = (data_own == ID_DC) ? dc_req_data_bits : ic_req_data_bits;
    mem_req_data_mask  = (data_own == ID_DC) ? dc_req_data_mask : ic_req_data_mask;
    ic_req_data_ready  = data_act && (data_own == ID_IC) && mem_req_data_ready;
    dc_req_data_ready  = data_act && (data_own == ID_DC) && mem_req_data_ready;
    data_fire          = mem_req_data_valid && mem_req_data_ready;
  end

  // Response steering: each response beat belongs to the oldest outstanding read
  always_comb begin
    push         = accept && !win_rw;
    pop          = !reset && mem_resp_val && !fifo_empty;
    ic_resp_val  = pop && (fifo_head == ID_IC);
    dc_resp_val  = pop && (fifo_head == ID_DC);
    ic_resp_data = mem_resp_data;
    dc_resp_data = mem_resp_data;
    arb_err      = err_q;
  end

  // FSM, write owner, sticky error and (optionally) round-robin pointer next-state
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    err_d   = err_q || (mem_resp_val && fifo_empty);
    case (state_q)
      ST_IDLE: begin
        if (accept && win_rw && !data_fire) begin
          state_d = ST_WDATA;
          owner_d = win_id;
        end
      end
      ST_WDATA: begin
        if (data_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef MEM_ARB_RR_EN
    rr_d = accept ? !win_id : rr_q;
`endif
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= ID_IC;
      err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_q    <= ID_DC;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q   <= err_d;
`ifdef MEM_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  mem_arb_tag_fifo #(
    .DEPTH(MAX_OUTST)
  ) u_tag_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .push_id(win_id),
    .pop    (pop),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter plus hand sequences for multi-cycle corners.
// Vectors apply one cycle each; outputs sampled mid-cycle, before the next rising edge.
// Works for both fixed priority and MEM_ARB_RR_EN builds.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = DW / 8;

  localparam logic [AW-1:0] IC_ADDR = 28'h0000040;
  localparam logic [AW-1:0] DC_ADDR = 28'h0000080;
  localparam logic [DW-1:0] IC_DAT  = {4{32'hAAAA_0001}};
  localparam logic [DW-1:0] DC_DAT  = {4{32'h5555_0002}};
  localparam logic [MW-1:0] IC_MSK  = 16'h00FF;
  localparam logic [MW-1:0] DC_MSK  = 16'hFF0F;

  logic clk = 1'b0;
  logic reset;
  logic ic_req_val, ic_req_rdy, ic_req_rw, ic_req_data_valid, ic_req_data_ready, ic_resp_val;
  logic dc_req_val, dc_req_rdy, dc_req_rw, dc_req_data_valid, dc_req_data_ready, dc_resp_val;
  logic [AW-1:0] ic_req_addr, dc_req_addr, mem_req_addr;
  logic [DW-1:0] ic_req_data_bits, dc_req_data_bits, ic_resp_data, dc_resp_data;
  logic [DW-1:0] mem_req_data_bits, mem_resp_data;
  logic [MW-1:0] ic_req_data_mask, dc_req_data_mask, mem_req_data_mask;
  logic mem_req_val, mem_req_rdy, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
  logic mem_resp_val, arb_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW), .MAX_OUTST(4)) dut (
    .clk(clk), .reset(reset),
    .ic_req_val(ic_req_val), .ic_req_rdy(ic_req_rdy), .ic_req_addr(ic_req_addr),
    .ic_req_rw(ic_req_rw), .ic_req_data_valid(ic_req_data_valid),
    .ic_req_data_ready(ic_req_data_ready), .ic_req_data_bits(ic_req_data_bits),
    .ic_req_data_mask(ic_req_data_mask), .ic_resp_val(ic_resp_val), .ic_resp_data(ic_resp_data),
    .dc_req_val(dc_req_val), .dc_req_rdy(dc_req_rdy), .dc_req_addr(dc_req_addr),
    .dc_req_rw(dc_req_rw), .dc_req_data_valid(dc_req_data_valid),
    .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
    .dc_req_data_mask(dc_req_data_mask), .dc_resp_val(dc_resp_val), .dc_resp_data(dc_resp_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask), .mem_resp_val(mem_resp_val),
    .mem_resp_data(mem_resp_data), .arb_err(arb_err)
  );

  // in  = {ic_val, ic_rw, dc_val, dc_rw, mem_rdy, resp_val, ic_dv, dc_dv, mem_drdy}
  // exp = {ic_rdy, dc_rdy, mem_val, mem_rw, ic_resp, dc_resp, mem_dval, ic_drdy, dc_drdy, err}
  typedef struct {
    string         name;
    logic [8:0]    in;
    logic [9:0]    exp;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, logic [8:0] i, logic [9:0] e, logic [AW-1:0] a);
    vec_t v;
    v.name = n; v.in = i; v.exp = e; v.addr = a;
    return v;
  endfunction

  function automatic logic [9:0] obs();
    return {ic_req_rdy, dc_req_rdy, mem_req_val, mem_req_rw, ic_resp_val, dc_resp_val,
            mem_req_data_valid, ic_req_data_ready, dc_req_data_ready, arb_err};
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [8:0] i);
    {ic_req_val, ic_req_rw, dc_req_val, dc_req_rw, mem_req_rdy, mem_resp_val,
     ic_req_data_valid, dc_req_data_valid, mem_req_data_ready} = i;
  endtask

  initial begin
    logic exp_dc;
    ic_req_addr = IC_ADDR; dc_req_addr = DC_ADDR;
    ic_req_data_bits = IC_DAT; dc_req_data_bits = DC_DAT;
    ic_req_data_mask = IC_MSK; dc_req_data_mask = DC_MSK;
    mem_resp_data = {4{32'hC0DE_F00D}};
    drive(9'b0);
    reset = 1'b1;

    // ---- vector table (one entry per cycle, state carries between rows) ----
    tbl.push_back(mk("ic_rd_stall",   9'b100000000, 10'b0010000000, IC_ADDR));
    tbl.push_back(mk("dch_unowned",   9'b000000011, 10'b0000000000, '0));
    tbl.push_back(mk("t1_ic_rd",      9'b100010000, 10'b1010000000, IC_ADDR));
    tbl.push_back(mk("t1_idle1",      9'b000000000, 10'b0000000000, '0));
    tbl.push_back(mk("t1_idle2",      9'b000000000, 10'b0000000000, '0));
    tbl.push_back(mk("t1_resp_ic",    9'b000001000, 10'b0000100000, '0));
    tbl.push_back(mk("t2_both_dc",    9'b101010000, 10'b0110000000, DC_ADDR));
    tbl.push_back(mk("t2_ic_next",    9'b100010000, 10'b1010000000, IC_ADDR));
    tbl.push_back(mk("t2_resp_dc",    9'b000001000, 10'b0000010000, '0));
    tbl.push_back(mk("t2_resp_ic",    9'b000001000, 10'b0000100000, '0));
    tbl.push_back(mk("t3_dc_wr",      9'b101110001, 10'b0111000010, DC_ADDR));
    tbl.push_back(mk("t3_wdata1",     9'b100010001, 10'b0000000010, '0));
    tbl.push_back(mk("t3_wdata2",     9'b100010001, 10'b0000000010, '0));
    tbl.push_back(mk("t3_dfire",      9'b100010011, 10'b0000001010, '0));
    tbl.push_back(mk("t3_ic_grant",   9'b100010000, 10'b1010000000, IC_ADDR));
    tbl.push_back(mk("t4_rd2",        9'b100010000, 10'b1010000000, IC_ADDR));
    tbl.push_back(mk("t4_rd3",        9'b100010000, 10'b1010000000, IC_ADDR));
    tbl.push_back(mk("t4_rd4",        9'b100010000, 10'b1010000000, IC_ADDR));
    tbl.push_back(mk("t4_rd5_block",  9'b100010000, 10'b0000000000, '0));
    tbl.push_back(mk("t4_wr_full",    9'b101110011, 10'b0111001010, DC_ADDR));
    tbl.push_back(mk("t4_pop_noubl",  9'b100011000, 10'b0000100000, '0));
    tbl.push_back(mk("t4_rd5_ok",     9'b100010000, 10'b1010000000, IC_ADDR));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk("t4_drain",    9'b000001000, 10'b0000100000, '0));
    tbl.push_back(mk("t5_stray",      9'b000001000, 10'b0000000000, '0));
    tbl.push_back(mk("t5_err_set",    9'b000000000, 10'b0000000001, '0));
    tbl.push_back(mk("t5_err_held",   9'b000000000, 10'b0000000001, '0));

    // ---- reset state ----
    tick(); tick();
    ic_req_val = 1'b1; dc_req_val = 1'b1; mem_req_rdy = 1'b1;
    #4;
    check("reset_outs", 128'(obs()), 128'(10'b0));
    tick();
    drive(9'b0);
    reset = 1'b0;

    // ---- table ----
    foreach (tbl[i]) begin
      drive(tbl[i].in);
      #4;
      check(tbl[i].name, 128'(obs()), 128'(tbl[i].exp));
      if (tbl[i].exp[7]) check({tbl[i].name, "_addr"}, 128'(mem_req_addr), 128'(tbl[i].addr));
      if (tbl[i].exp[3]) check({tbl[i].name, "_wdat"}, mem_req_data_bits, DC_DAT);
      tick();
    end
    drive(9'b0);

    // ---- reset clears sticky error ----
    reset = 1'b1;
    tick();
    #4;
    check("t5_err_clr", 128'(arb_err), 128'(1'b0));
    reset = 1'b0;
    tick();

    // ---- both requesting reads continuously ----
    drive(9'b101010000);
    for (int i = 0; i < 4; i++) begin
      #4;
`ifdef MEM_ARB_RR_EN
      exp_dc = (i % 2 == 0);
`else
      exp_dc = 1'b1;
`endif
      check("t6_grant", 128'({ic_req_rdy, dc_req_rdy}), 128'({!exp_dc, exp_dc}));
      tick();
    end
    drive(9'b000001000);
    for (int i = 0; i < 4; i++) begin
      #4;
`ifdef MEM_ARB_RR_EN
      exp_dc = (i % 2 == 0);
`else
      exp_dc = 1'b1;
`endif
      check("t6_route", 128'({ic_resp_val, dc_resp_val}), 128'({!exp_dc, exp_dc}));
      tick();
    end

    // ---- ic write with data in the same cycle ----
    drive(9'b110010101);
    #4;
    check("icwr_ctl", 128'(obs()), 128'(10'b1011001100));
    check("icwr_bits", mem_req_data_bits, IC_DAT);
    check("icwr_mask", 128'(mem_req_data_mask), 128'(IC_MSK));
    tick();

    // ---- reset mid-write with a read outstanding ----
    drive(9'b100010000);
    #4;
    check("rmw_ic_rd", 128'(ic_req_rdy), 128'(1'b1));
    tick();
    drive(9'b001110000);
    #4;
    check("rmw_dc_wr", 128'(dc_req_rdy), 128'(1'b1));
    tick();
    drive(9'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(9'b000001000);
    #4;
    check("rmw_stray", 128'({ic_resp_val, dc_resp_val}), 128'(2'b00));
    tick();
    drive(9'b100010000);
    #4;
    check("rmw_idle_grant", 128'({ic_req_rdy, arb_err}), 128'(2'b11));
    tick();
    drive(9'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
